korforgo_utemezo: RTL
=====================

# korforgo_utemezo

Round-robin scheduler that shares one 8-way resource between eight requesters. It selects one requester at a time and drives both the 3-bit select index and its registered one-hot grant vector, matching the 3-to-8 address decoder encoding (index n → bit n). It bounds each tenure with a hold timeout and inserts a guaranteed idle gap between owners.

## Interface
- HOLD_MAX, 15: maximum cycles a grant may be held (1..255); forced release when reached
- CW, 8: width of the internal hold counter; must satisfy 2^CW > HOLD_MAX
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  asynchronous active-low reset; deasserted synchronously externally
- req  input  8  request per requester; bit n = requester n, level-sensitive
- done  input  1  current owner releases the resource (sampled only in GRANT)
- gnt  output  8  registered one-hot grant, bit gnt_idx set only in GRANT, else 8'b0
- gnt_idx  output  3  binary index of current/last owner
- gnt_valid  output  1  high exactly while in GRANT
- timeout  output  1  one-cycle pulse when a tenure was forcibly ended by HOLD_MAX

## Operation
- States: IDLE, GRANT, GAP. Reset state IDLE.
- IDLE: if req != 0, pick winner = first set bit of req searching upward from (ptr+1) mod 8, wrapping 7→0; load gnt_idx = winner, ptr = winner, hold counter = 1, go GRANT. If req == 0, stay IDLE.
- GRANT: gnt = decode(gnt_idx), gnt_valid = 1. Release condition at an edge: done = 1, or req[gnt_idx] = 0, or counter == HOLD_MAX. On release go GAP; otherwise counter += 1.
- Timeout: if counter == HOLD_MAX and done = 0 and req[gnt_idx] = 1 at the edge, set timeout = 1 for the GAP cycle. A normal release coinciding with counter == HOLD_MAX is not a timeout.
- GAP: gnt = 0, gnt_valid = 0, one cycle always; then IDLE. Requests are not evaluated in GAP.
- Fairness: the requester just served has lowest priority in the next arbitration. No requester waits more than 7 tenures.
- Requests changing in GRANT for other bits are ignored until next IDLE.
- gnt_idx holds its value outside GRANT (last owner).
- Counter saturates logically: never exceeds HOLD_MAX; no wrap.

## Timing
- Reset (async, immediate): state IDLE, gnt = 8'b0, gnt_idx = 3'd7, ptr = 3'd7 (first search starts at requester 0), gnt_valid = 0, timeout = 0, counter = 0.
- Grant latency: req sampled high in IDLE at edge k → gnt/gnt_valid high in cycle after edge k (1 cycle).
- Release latency: release condition at edge m → gnt = 0 from after edge m; GAP occupies cycle m..m+1; IDLE after edge m+1; earliest next grant after edge m+2.
- Maximum tenure: HOLD_MAX cycles with gnt_valid high.
- rst_n low mid-GRANT: gnt drops to 0 asynchronously; after release, arbitration restarts from requester 0.
- All outputs are registered; no combinational path from req/done to any output.

## Test plan
- Reset then req = 8'b0000_0001, done after 3 grant cycles → gnt = 8'h01, gnt_idx = 0 for 3 cycles, then 2 cycles of gnt = 0, timeout never set.
- req = 8'hFF held, done pulsed every grant cycle → grant order 0,1,2,…,7,0 with gnt = 8'h01,8'h02,…,8'h80,8'h01; each grant separated by 2 zero cycles.
- req = 8'b1000_0100, ptr = 2 after serving requester 2 → next grant is 7 (gnt = 8'h80), then 2 (wrap-around search).
- HOLD_MAX = 4, req[5] held high, done = 0 → gnt = 8'h20 for exactly 4 cycles, timeout = 1 in the following cycle only, re-grant to 5 two cycles later if sole requester.
- done = 1 on the same edge counter == HOLD_MAX → release with timeout = 0; req[3] dropped mid-grant → release next edge, timeout = 0.
- rst_n asserted during GRANT to requester 6 → gnt = 8'h00 immediately, gnt_idx = 7; after release with req = 8'h41 first grant goes to requester 0.

Source files
------------

// File: rtl/korforgo_utemezo.sv
// Round-robin scheduler granting one of eight requesters at a time.
// Each tenure is capped at HOLD_MAX cycles, and a one-cycle gap is inserted between owners.
module korforgo_utemezo #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] holdCnt_q, holdCnt_d;
  logic [7:0]    gnt_q, gnt_d;
  logic          timeout_q, timeout_d;

  logic [2:0]    winner;
  logic [2:0]    cand;
  logic          found;
  logic          atMax;
  logic          release_c;

  // The last owner doubles as the round-robin pointer, so the search starts just above it.
  always_comb begin
    winner = idx_q;
    cand   = idx_q;
    found  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cand = idx_q + 3'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign atMax     = (holdCnt_q == CW'(HOLD_MAX));
  assign release_c = done || !req[idx_q] || atMax;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    holdCnt_d = holdCnt_q;
    gnt_d     = 8'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          idx_d     = winner;
          holdCnt_d = CW'(1);
          gnt_d     = 8'b1 << winner;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (release_c) begin
          state_d   = GAP;
          timeout_d = atMax && !done && req[idx_q];
        end else begin
          holdCnt_d = holdCnt_q + CW'(1);
          gnt_d     = gnt_q;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 3'd7;
      holdCnt_q <= '0;
      gnt_q     <= 8'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      holdCnt_q <= holdCnt_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == GRANT);
  assign timeout   = timeout_q;

endmodule
